// File: rtl/rv_bp_pkg.sv
// rtl/rv_bp_pkg.sv - shared types and helpers for the branch predictor
// Purpose: counter encodings, counter init values and PC index/tag split.
// Ports: none (package).
package rv_bp_pkg;

    // Named encodings for the common 2-bit bimodal counter.
    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt2_e;

    // Weakly taken: MSB set, all lower bits clear.
    function automatic logic [31:0] cnt_weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic logic [31:0] cnt_weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Word-aligned PCs: bits [1:0] never take part in indexing.
    function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/rv_branch_predictor_if.sv
// rtl/rv_branch_predictor_if.sv - fetch lookup / execute resolve bundle
// Purpose: groups the pipeline-facing predictor signals.
// master: pipeline side (drives pc_f, flush and resolved outcome).
// slave:  predictor side (returns prediction, mispredict and redirect PC).
interface rv_branch_predictor_if #(
    parameter int XLEN = 32
);
    logic            pc_f_valid_unused;
    logic [XLEN-1:0] pc_f;
    logic            pred_taken_f;
    logic [XLEN-1:0] pred_target_f;
    logic            bp_flush;
    logic            upd_valid_e;
    logic [XLEN-1:0] upd_pc_e;
    logic            upd_is_jump_e;
    logic            upd_taken_e;
    logic [XLEN-1:0] upd_target_e;
    logic            pred_taken_e;
    logic [XLEN-1:0] pred_target_e;
    logic            mispredict_e;
    logic [XLEN-1:0] redirect_pc_e;

    modport master (
        output pc_f, bp_flush, upd_valid_e, upd_pc_e, upd_is_jump_e, upd_taken_e,
               upd_target_e, pred_taken_e, pred_target_e,
        input  pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e
    );

    modport slave (
        input  pc_f, bp_flush, upd_valid_e, upd_pc_e, upd_is_jump_e, upd_taken_e,
               upd_target_e, pred_taken_e, pred_target_e,
        output pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e
    );
endinterface

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - saturating up/down counter for one BHT entry
// Purpose: bimodal history counter; resets weakly not-taken.
// Ports: clk, rst_n (async active-low), load (set weakly taken),
//        inc/dec (saturating step), cnt_q (current value).
module bp_sat_counter
    import rv_bp_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt_q
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_weak_not_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(cnt_weak_taken(CNT_W));

    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_LOAD;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rv_branch_predictor.sv
// rtl/rv_branch_predictor.sv - BTB + bimodal BHT dynamic branch predictor
// Purpose: 0-cycle fetch prediction, execute-stage resolve/redirect, table update.
// Ports: clk, rst_n (async active-low), bp (slave modport of the predictor bundle),
//        perf_ctl / perf_miss (saturating counts of resolved instrs / mispredicts).
module rv_branch_predictor
    import rv_bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv_branch_predictor_if.slave  bp,
    output logic [PERF_W-1:0]     perf_ctl,
    output logic [PERF_W-1:0]     perf_miss
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Tables are flops so they clear asynchronously and read in the same cycle.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jump_q, jump_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [ENTRIES-1:0] cnt_load, cnt_inc, cnt_dec;
    logic [PERF_W-1:0]  perf_ctl_q, perf_ctl_d, perf_miss_q, perf_miss_d;

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e, pred_taken_f, mispredict_e;

    assign idx_f = IDX_W'(pc_idx(64'(bp.pc_f), IDX_W));
    assign tag_f = TAG_W'(pc_tag(64'(bp.pc_f), IDX_W));
    assign idx_e = IDX_W'(pc_idx(64'(bp.upd_pc_e), IDX_W));
    assign tag_e = TAG_W'(pc_tag(64'(bp.upd_pc_e), IDX_W));

    // Lookup sees only pre-edge table contents; no bypass from the update path.
    always_comb begin
        hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        hit_e         = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        pred_taken_f  = hit_f && (jump_q[idx_f] || cnt_q[idx_f][CNT_W-1]);
    end

    assign bp.pred_taken_f  = pred_taken_f;
    assign bp.pred_target_f = pred_taken_f ? target_q[idx_f] : bp.pc_f + XLEN'(4);

    always_comb begin
        mispredict_e     = 1'b0;
        bp.redirect_pc_e = '0;
        if (bp.upd_valid_e) begin
            if (bp.upd_taken_e && (!bp.pred_taken_e || (bp.pred_target_e != bp.upd_target_e))) begin
                mispredict_e     = 1'b1;
                bp.redirect_pc_e = bp.upd_target_e;
            end else if (!bp.upd_taken_e && bp.pred_taken_e) begin
                mispredict_e     = 1'b1;
                bp.redirect_pc_e = bp.upd_pc_e + XLEN'(4);
            end
        end
    end

    assign bp.mispredict_e = mispredict_e;

    // Flush overrides any concurrent table write; counters keep their history.
    always_comb begin
        valid_d  = valid_q;
        jump_d   = jump_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_load = '0;
        cnt_inc  = '0;
        cnt_dec  = '0;
        if (bp.bp_flush) begin
            valid_d = '0;
        end else if (bp.upd_valid_e) begin
            if (bp.upd_taken_e) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = bp.upd_target_e;
                jump_d[idx_e]   = bp.upd_is_jump_e;
                if (hit_e) begin
                    cnt_inc[idx_e] = 1'b1;
                end else begin
                    cnt_load[idx_e] = 1'b1;
                end
            end else if (hit_e) begin
                cnt_dec[idx_e] = 1'b1;
            end
        end
    end

    always_comb begin
        perf_ctl_d  = perf_ctl_q;
        perf_miss_d = perf_miss_q;
        if (bp.upd_valid_e && !(&perf_ctl_q)) begin
            perf_ctl_d = perf_ctl_q + PERF_W'(1);
        end
        if (mispredict_e && !(&perf_miss_q)) begin
            perf_miss_d = perf_miss_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            jump_q      <= '0;
            perf_ctl_q  <= '0;
            perf_miss_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            jump_q      <= jump_d;
            tag_q       <= tag_d;
            target_q    <= target_d;
            perf_ctl_q  <= perf_ctl_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_ctl  = perf_ctl_q;
    assign perf_miss = perf_miss_q;

    for (genvar e = 0; e < ENTRIES; e++) begin : g_cnt
        bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (cnt_load[e]),
            .inc   (cnt_inc[e]),
            .dec   (cnt_dec[e]),
            .cnt_q (cnt_q[e])
        );
    end
endmodule
